// File: rtl/booth_algorithm_dv_seq_if.sv
// Operand/product bundle for the sequential Booth multiplier.
// in1: multiplicand, in2: multiplier, out: {A[3:0],Q[3:0],Q_-1}.
interface booth_algorithm_dv_seq_if;
  logic [3:0] in1;
  logic [3:0] in2;
  logic [8:0] out;

  modport master (
    output in1,
    output in2,
    input  out
  );

  modport slave (
    input  in1,
    input  in2,
    output out
  );
endinterface

// File: rtl/booth_algorithm_dv_seq.sv
// Free-running radix-2 Booth multiplier, 4x4 signed -> 8-bit product.
// Ports: clk, n_rst (async, active-high), bus.in1/in2 (operands), bus.out.
module booth_algorithm_dv_seq (
  input  logic                   clk,
  input  logic                   n_rst,
  booth_algorithm_dv_seq_if.slave bus
);

  typedef enum logic [1:0] {
    LOAD,
    ITER,
    DONE
  } state_t;

  state_t     r_state;
  logic [4:0] r_a;
  logic [3:0] r_q;
  logic       r_q1;
  logic [3:0] r_m;
  logic [3:0] r_ql;
  logic [2:0] r_cnt;

  logic [4:0] w_mx;
  logic [4:0] w_sum;
  logic       w_chg;

  // A carries an extra sign bit so that subtracting M=-8 cannot overflow.
  assign w_mx  = {r_m[3], r_m};
  assign w_chg = (bus.in1 != r_m) || (bus.in2 != r_ql);

  always_comb begin
    w_sum = r_a;
    unique case ({r_q[0], r_q1})
      2'b01:   w_sum = r_a + w_mx;
      2'b10:   w_sum = r_a - w_mx;
      default: w_sum = r_a;
    endcase
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_state <= LOAD;
      r_a     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_m     <= '0;
      r_ql    <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        LOAD: begin
          r_m     <= bus.in1;
          r_ql    <= bus.in2;
          r_a     <= '0;
          r_q     <= bus.in2;
          r_q1    <= 1'b0;
          r_cnt   <= '0;
          r_state <= ITER;
        end
        ITER: begin
          // Add/sub and arithmetic right shift of {A,Q,Q_-1} in one cycle.
          r_a   <= {w_sum[4], w_sum[4:1]};
          r_q   <= {w_sum[0], r_q[3:1]};
          r_q1  <= r_q[0];
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd3) r_state <= DONE;
        end
        DONE: begin
          if (w_chg) r_state <= LOAD;
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign bus.out = {r_a[3:0], r_q, r_q1};

endmodule

// File: tb/tb_booth_algorithm_dv_seq.sv
// Scoreboard bench for booth_algorithm_dv_seq.
// Expected outputs are queued on drive and popped when the product is due.
module tb_booth_algorithm_dv_seq;

  logic clk;
  logic n_rst;
  int   n_chk;
  int   n_err;

  logic [8:0] q_exp[$];

  booth_algorithm_dv_seq_if u_if ();

  booth_algorithm_dv_seq u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ref_out(
    input logic [3:0] a,
    input logic [3:0] b
  );
    int p;
    logic [7:0] p8;
    p  = int'($signed(a)) * int'($signed(b));
    p8 = p[7:0];
    // Q_-1 ends holding the multiplier's top bit after four shifts.
    return {p8, b[3]};
  endfunction

  task automatic chk(
    input string      tag,
    input logic [8:0] got,
    input logic [8:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b);
    u_if.in1 = a;
    u_if.in2 = b;
    q_exp.push_back(ref_out(a, b));
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop_chk(input string tag);
    logic [8:0] e;
    if (q_exp.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s got=%h exp=empty", tag, u_if.out);
    end else begin
      e = q_exp.pop_front();
      chk(tag, u_if.out, e);
    end
  endtask

  initial begin
    logic [8:0] hold;
    n_chk = 0;
    n_err = 0;
    n_rst = 1'b1;
    u_if.in1 = 4'd7;
    u_if.in2 = 4'd3;

    repeat (2) begin
      @(negedge clk);
      chk("rst_out", u_if.out, 9'h000);
    end

    drive(4'd7, 4'd3);
    n_rst = 1'b0;
    edges(5);
    chk("p7x3_lit", u_if.out, 9'b000101010);
    pop_chk("p7x3");
    hold = ref_out(4'd7, 4'd3);
    edges(3);
    chk("p7x3_hold", u_if.out, hold);

    drive(4'd2, 4'hC);
    edges(6);
    pop_chk("p2xm4");

    drive(4'h8, 4'h8);
    edges(6);
    pop_chk("pm8xm8");

    drive(4'h8, 4'd7);
    edges(6);
    pop_chk("pm8x7");

    drive(4'hD, 4'd5);
    edges(6);
    pop_chk("pm3x5");

    drive(4'd0, 4'hF);
    edges(6);
    pop_chk("p0xm1");

    // Operand change mid-computation is ignored until DONE, then reloads.
    drive(4'd2, 4'hC);
    edges(3);
    drive(4'd5, 4'd5);
    edges(3);
    pop_chk("iter_ign");
    edges(6);
    pop_chk("reload");

    // Async reset during ITER aborts at once.
    drive(4'd6, 4'hB);
    edges(3);
    #2;
    n_rst = 1'b1;
    #1;
    chk("async_rst", u_if.out, 9'h000);
    @(negedge clk);
    chk("rst_hold", u_if.out, 9'h000);
    n_rst = 1'b0;
    edges(5);
    pop_chk("post_rst");

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        drive(4'(a), 4'(b));
        edges(6);
        pop_chk("exh");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end

endmodule
